// File: rtl/bcd_seg7_display_pkg.sv
// Shared types and constants for the BCD seven-segment display slice.
// Segment patterns are active-high here; polarity is applied per digit.
package bcd_seg7_display_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t SHIFT = 2'd1;
  localparam state_t LATCH = 2'd2;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;

  // Entry n holds the pattern for decimal digit n (bit 0 = a ... bit 6 = g).
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
    7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/bcd_seg7_display_if.sv
// Load/busy/done handshake plus result bus between the requester and the converter.
interface bcd_seg7_display_if #(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
);
  logic [BIN_W-1:0]    BIN_IN;
  logic                LOAD;
  logic                BUSY;
  logic                DONE;
  logic [4*DIGITS-1:0] BCD_OUT;
  logic                OVERFLOW;
  logic [7*DIGITS-1:0] HEX_OUT;

  modport master (
    output BIN_IN, LOAD,
    input  BUSY, DONE, BCD_OUT, OVERFLOW, HEX_OUT
  );

  modport slave (
    input  BIN_IN, LOAD,
    output BUSY, DONE, BCD_OUT, OVERFLOW, HEX_OUT
  );
endinterface

// File: rtl/bcd_seg7_display_seg7_digit.sv
// Combinational BCD-to-seven-segment decoder with blank and dash overrides.
module seg7_digit
  import bcd_seg7_display_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] bcd,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);

  logic [6:0] lit;

  always_comb begin
    lit = SEG_BLANK;
    if (dash)
      lit = SEG_DASH;
    else if (!blank && bcd <= 4'd9)
      lit = SEG_TABLE[bcd];
    seg = SEG_ACTIVE_LOW ? ~lit : lit;
  end

endmodule

// File: rtl/bcd_seg7_display.sv
// Sequential double-dabble binary-to-BCD converter driving DIGITS seven-segment
// displays with leading-zero blanking and overflow dashes.
module bcd_seg7_display
  import bcd_seg7_display_pkg::*;
#(
  parameter int unsigned BIN_W          = 8,
  parameter int unsigned DIGITS         = 3,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          BLANK_LEADING  = 1'b1
) (
  input  logic CLOCK_50,
  input  logic RESET,
  bcd_seg7_display_if.slave bus
);

  localparam int unsigned SW    = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  state_t             state;
  logic [BIN_W-1:0]   bin_q;
  logic [SW-1:0]      scratch;
  logic [SW-1:0]      adj;
  logic [SW-1:0]      bcd_q;
  logic [CNT_W-1:0]   cnt;
  logic               sticky;
  logic               ovf_q;
  logic               busy_q;
  logic               done_q;
  logic [7*DIGITS-1:0] hex;

  always_comb begin
    adj = scratch;
    for (int unsigned i = 0; i < DIGITS; i++)
      if (adj[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state   <= IDLE;
      bin_q   <= '0;
      scratch <= '0;
      cnt     <= '0;
      sticky  <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.LOAD) begin
            bin_q   <= bus.BIN_IN;
            scratch <= '0;
            sticky  <= 1'b0;
            cnt     <= CNT_W'(BIN_W);
            busy_q  <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          // Lower digits never depend on the bit leaving the top digit, so
          // dropping it yields the value mod 10^DIGITS; it only flags overflow.
          scratch <= {adj[SW-2:0], bin_q[BIN_W-1]};
          bin_q   <= bin_q << 1;
          sticky  <= sticky | adj[SW-1];
          cnt     <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1))
            state <= LATCH;
        end
        LATCH: begin
          bcd_q  <= scratch;
          ovf_q  <= sticky;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    logic blank;
    if (k == 0) begin : g_units
      assign blank = 1'b0;
    end else begin : g_upper
      assign blank = BLANK_LEADING && (bcd_q[SW-1:4*k] == '0);
    end
    seg7_digit #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_digit (
      .bcd   (bcd_q[4*k +: 4]),
      .blank (blank),
      .dash  (ovf_q),
      .seg   (hex[7*k +: 7])
    );
  end

  assign bus.BUSY     = busy_q;
  assign bus.DONE     = done_q;
  assign bus.BCD_OUT  = bcd_q;
  assign bus.OVERFLOW = ovf_q;
  assign bus.HEX_OUT  = hex;

endmodule

// File: tb/tb_bcd_seg7_display.sv
// Directed bench: three converter instances (default, no blanking, two digits)
// share clock, reset and stimulus.
module tb_bcd_seg7_display;

  logic       clk;
  logic       rst;
  logic [7:0] bin;
  logic       load;
  int         errors;
  int         checks;

  bcd_seg7_display_if #(.BIN_W(8), .DIGITS(3)) if0 ();
  bcd_seg7_display_if #(.BIN_W(8), .DIGITS(3)) if1 ();
  bcd_seg7_display_if #(.BIN_W(8), .DIGITS(2)) if2 ();

  assign if0.BIN_IN = bin;
  assign if0.LOAD   = load;
  assign if1.BIN_IN = bin;
  assign if1.LOAD   = load;
  assign if2.BIN_IN = bin;
  assign if2.LOAD   = load;

  bcd_seg7_display #(.BIN_W(8), .DIGITS(3)) u0 (
    .CLOCK_50 (clk), .RESET (rst), .bus (if0.slave)
  );
  bcd_seg7_display #(.BIN_W(8), .DIGITS(3), .BLANK_LEADING(1'b0)) u1 (
    .CLOCK_50 (clk), .RESET (rst), .bus (if1.slave)
  );
  bcd_seg7_display #(.BIN_W(8), .DIGITS(2)) u2 (
    .CLOCK_50 (clk), .RESET (rst), .bus (if2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [7:0] value);
    bin  = value;
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  // Called right after the accepting edge; expects DONE exactly 9 edges later.
  task automatic wait_done(input string tag, input logic [31:0] held_bcd, input bit inject);
    int n;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      if (inject && i == 3) begin
        bin  = 8'd10;
        load = 1'b1;
      end
      @(posedge clk); #1;
      if (inject && i == 3) load = 1'b0;
      if (i == 4) begin
        chk({tag, "_busy_mid"}, {31'd0, if0.BUSY}, 32'd1);
        chk({tag, "_held_mid"}, {20'd0, if0.BCD_OUT}, held_bcd);
      end
      if (if0.DONE) begin
        n = i;
        break;
      end
    end
    chk({tag, "_latency"}, n, 32'd9);
    chk({tag, "_busy_done"}, {31'd0, if0.BUSY}, 32'd0);
    chk({tag, "_done_u2"}, {31'd0, if2.DONE}, 32'd1);
  endtask

  task automatic check_pulse_end(input string tag);
    @(posedge clk); #1;
    chk({tag, "_done_low"}, {31'd0, if0.DONE}, 32'd0);
    chk({tag, "_busy_low"}, {31'd0, if0.BUSY}, 32'd0);
  endtask

  initial begin
    int dn;
    errors = 0;
    checks = 0;
    rst  = 1'b1;
    bin  = '0;
    load = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_busy", {31'd0, if0.BUSY}, 32'd0);
    chk("rst_done", {31'd0, if0.DONE}, 32'd0);
    chk("rst_bcd", {20'd0, if0.BCD_OUT}, 32'h000);
    chk("rst_ovf", {31'd0, if0.OVERFLOW}, 32'd0);
    chk("rst_hex", {11'd0, if0.HEX_OUT}, {11'd0, 7'h7F, 7'h7F, 7'h40});
    chk("rst_hex_noblank", {11'd0, if1.HEX_OUT}, {11'd0, 7'h40, 7'h40, 7'h40});
    chk("rst_hex_2dig", {18'd0, if2.HEX_OUT}, {18'd0, 7'h7F, 7'h40});

    start(8'd255);
    wait_done("v255", 32'h000, 1'b0);
    chk("v255_bcd", {20'd0, if0.BCD_OUT}, 32'h255);
    chk("v255_ovf", {31'd0, if0.OVERFLOW}, 32'd0);
    chk("v255_hex", {11'd0, if0.HEX_OUT}, {11'd0, 7'h24, 7'h12, 7'h12});
    chk("v255_hex_noblank", {11'd0, if1.HEX_OUT}, {11'd0, 7'h24, 7'h12, 7'h12});
    chk("v255_2dig_ovf", {31'd0, if2.OVERFLOW}, 32'd1);
    chk("v255_2dig_bcd", {24'd0, if2.BCD_OUT}, 32'h55);
    chk("v255_2dig_hex", {18'd0, if2.HEX_OUT}, {18'd0, 7'h3F, 7'h3F});
    check_pulse_end("v255");

    start(8'd7);
    wait_done("v7", 32'h255, 1'b0);
    chk("v7_bcd", {20'd0, if0.BCD_OUT}, 32'h007);
    chk("v7_hex", {11'd0, if0.HEX_OUT}, {11'd0, 7'h7F, 7'h7F, 7'h78});
    chk("v7_hex_noblank", {11'd0, if1.HEX_OUT}, {11'd0, 7'h40, 7'h40, 7'h78});
    chk("v7_2dig_hex", {18'd0, if2.HEX_OUT}, {18'd0, 7'h7F, 7'h78});

    start(8'd100);
    wait_done("v100", 32'h007, 1'b0);
    chk("v100_bcd", {20'd0, if0.BCD_OUT}, 32'h100);
    chk("v100_hex", {11'd0, if0.HEX_OUT}, {11'd0, 7'h79, 7'h40, 7'h40});
    chk("v100_2dig_ovf", {31'd0, if2.OVERFLOW}, 32'd1);
    chk("v100_2dig_bcd", {24'd0, if2.BCD_OUT}, 32'h00);
    chk("v100_2dig_hex", {18'd0, if2.HEX_OUT}, {18'd0, 7'h3F, 7'h3F});

    start(8'd99);
    wait_done("v99", 32'h100, 1'b0);
    chk("v99_2dig_ovf", {31'd0, if2.OVERFLOW}, 32'd0);
    chk("v99_2dig_bcd", {24'd0, if2.BCD_OUT}, 32'h99);
    chk("v99_2dig_hex", {18'd0, if2.HEX_OUT}, {18'd0, 7'h10, 7'h10});
    chk("v99_hex", {11'd0, if0.HEX_OUT}, {11'd0, 7'h7F, 7'h10, 7'h10});

    // A LOAD of 10 lands at t+3 while busy and must be dropped.
    start(8'd255);
    wait_done("busyload", 32'h099, 1'b1);
    chk("busyload_bcd", {20'd0, if0.BCD_OUT}, 32'h255);
    dn = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (if0.DONE) dn++;
    end
    chk("busyload_single_done", dn, 32'd0);

    start(8'd10);
    wait_done("v10", 32'h255, 1'b0);
    chk("v10_bcd", {20'd0, if0.BCD_OUT}, 32'h010);
    chk("v10_hex", {11'd0, if0.HEX_OUT}, {11'd0, 7'h7F, 7'h79, 7'h40});

    start(8'd255);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, if0.BUSY}, 32'd0);
    chk("midrst_done", {31'd0, if0.DONE}, 32'd0);
    chk("midrst_bcd", {20'd0, if0.BCD_OUT}, 32'h000);
    chk("midrst_hex", {11'd0, if0.HEX_OUT}, {11'd0, 7'h7F, 7'h7F, 7'h40});
    @(posedge clk); #1;
    rst = 1'b0;
    dn = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (if0.DONE) dn++;
    end
    chk("midrst_no_done", dn, 32'd0);

    start(8'd42);
    wait_done("v42", 32'h000, 1'b0);
    chk("v42_bcd", {20'd0, if0.BCD_OUT}, 32'h042);
    chk("v42_hex", {11'd0, if0.HEX_OUT}, {11'd0, 7'h7F, 7'h19, 7'h24});
    chk("v42_2dig_bcd", {24'd0, if2.BCD_OUT}, 32'h42);
    check_pulse_end("v42");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
